// File: rtl/ring_link_tx.sv
// Ring node egress: merges pass-through and local flits with bounded starvation,
// registers the winner onto the link and tracks downstream credits.
module ring_link_tx #(
  parameter int WIDTH      = 64,
  parameter int CREDITS    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iPassVld,
  input  logic [WIDTH-1:0] iPassDat,
  output logic             oPassRdy,
  input  logic             iEmpty,
  input  logic [WIDTH-1:0] iRdDat,
  output logic             oRdEn,
  output logic             oVld,
  output logic [WIDTH-1:0] oDat,
  input  logic             iCrdRet,
  output logic [3:0]       oCrd,
  output logic             oCrdErr,
  output logic [15:0]      oTxCnt
);

  localparam logic [3:0] CRD_MAX   = 4'(CREDITS);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]       crd_reg, crd_next;
  logic [3:0]       starve_reg, starve_next;
  logic             vld_reg;
  logic [WIDTH-1:0] dat_reg;
  logic             err_reg, err_next;
  logic [15:0]      tx_cnt_reg;

  logic can_send, pass_pend, loc_pend;
  logic grant_pass, grant_loc, grant;

  assign can_send  = (crd_reg != 4'd0);
  assign pass_pend = iPassVld;
  assign loc_pend  = !iEmpty;

  // Grants are suppressed while reset is held so the local FIFO is never popped.
  always_comb begin
    grant_pass = 1'b0;
    grant_loc  = 1'b0;
    if (rst && can_send) begin
      if (pass_pend && loc_pend) begin
        if (starve_reg == STARVE_LIM) grant_loc = 1'b1;
        else                          grant_pass = 1'b1;
      end else if (pass_pend) begin
        grant_pass = 1'b1;
      end else if (loc_pend) begin
        grant_loc = 1'b1;
      end
    end
  end

  assign grant    = grant_pass | grant_loc;
  assign oPassRdy = grant_pass;
  assign oRdEn    = grant_loc;

  always_comb begin
    crd_next = crd_reg;
    err_next = err_reg;
    case ({grant, iCrdRet})
      2'b10: crd_next = crd_reg - 4'd1;
      2'b01: begin
        if (crd_reg == CRD_MAX) err_next = 1'b1;
        else                    crd_next = crd_reg + 4'd1;
      end
      default: crd_next = crd_reg;
    endcase
  end

  // Counts pass grants made while a local flit waits; holds on credit stalls.
  always_comb begin
    starve_next = starve_reg;
    if (!loc_pend || grant_loc) starve_next = 4'd0;
    else if (grant_pass)        starve_next = starve_reg + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      crd_reg    <= CRD_MAX;
      starve_reg <= 4'd0;
      vld_reg    <= 1'b0;
      dat_reg    <= '0;
      err_reg    <= 1'b0;
      tx_cnt_reg <= 16'd0;
    end else begin
      crd_reg    <= crd_next;
      starve_reg <= starve_next;
      err_reg    <= err_next;
      vld_reg    <= grant;
      if (grant) begin
        dat_reg    <= grant_pass ? iPassDat : iRdDat;
        tx_cnt_reg <= tx_cnt_reg + 16'd1;
      end
    end
  end

  assign oVld    = vld_reg;
  assign oDat    = dat_reg;
  assign oCrd    = crd_reg;
  assign oCrdErr = err_reg;
  assign oTxCnt  = tx_cnt_reg;

endmodule

// File: tb/tb_ring_link_tx.sv
// Randomized and directed bench for ring_link_tx against a cycle-level
// behavioural model of arbitration, credits and link output.
module tb_ring_link_tx;
  localparam int WIDTH      = 64;
  localparam int CREDITS    = 2;
  localparam int STARVE_MAX = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             iPassVld;
  logic [WIDTH-1:0] iPassDat;
  logic             oPassRdy;
  logic             iEmpty;
  logic [WIDTH-1:0] iRdDat;
  logic             oRdEn;
  logic             oVld;
  logic [WIDTH-1:0] oDat;
  logic             iCrdRet;
  logic [3:0]       oCrd;
  logic             oCrdErr;
  logic [15:0]      oTxCnt;

  ring_link_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .iPassVld(iPassVld), .iPassDat(iPassDat), .oPassRdy(oPassRdy),
    .iEmpty(iEmpty), .iRdDat(iRdDat), .oRdEn(oRdEn),
    .oVld(oVld), .oDat(oDat),
    .iCrdRet(iCrdRet), .oCrd(oCrd), .oCrdErr(oCrdErr), .oTxCnt(oTxCnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int               m_crd;
  int               m_waited;   // pass grants given while the local flit waited
  bit               m_vld;
  logic [WIDTH-1:0] m_dat;
  bit               m_err;
  int               m_tx;
  logic [WIDTH-1:0] lq[$];      // local FIFO contents, head at index 0

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_crd = CREDITS; m_waited = 0; m_vld = 0; m_dat = '0; m_err = 0; m_tx = 0;
  endtask

  // One clock cycle: drive, check current outputs against the model, advance.
  task automatic step(input bit r, input bit pv, input logic [WIDTH-1:0] pd, input bit cr);
    bit loc, gp, gl;
    @(negedge clk);
    rst      = r;
    iPassVld = pv;
    iPassDat = pd;
    iEmpty   = (lq.size() == 0);
    iRdDat   = (lq.size() != 0) ? lq[0] : {$urandom, $urandom};
    iCrdRet  = cr;
    #1;
    loc = (lq.size() != 0);
    gp = 0; gl = 0;
    if (r && m_crd > 0) begin
      if (pv && (!loc || m_waited < STARVE_MAX)) gp = 1;
      else if (loc) gl = 1;
    end
    check("pass_rdy", oPassRdy, gp);
    check("rd_en", oRdEn, gl);
    check("vld", oVld, m_vld);
    check("dat", oDat, m_dat);
    check("crd", oCrd, m_crd);
    check("crd_err", oCrdErr, m_err);
    check("tx_cnt", oTxCnt, m_tx);
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      m_vld = gp || gl;
      if (m_vld) begin
        m_dat = gp ? pd : lq[0];
        m_tx  = (m_tx + 1) % 65536;
      end
      m_crd = m_crd - int'(m_vld) + int'(cr);
      if (m_crd > CREDITS) begin
        m_crd = CREDITS;
        m_err = 1;
      end
      if (!loc || gl) m_waited = 0;
      else if (gp)    m_waited++;
      if (gl) void'(lq.pop_front());
    end
  endtask

  initial begin
    logic [WIDTH-1:0] pd;
    rst = 1'b0; iPassVld = 0; iPassDat = '0; iEmpty = 1; iRdDat = '0; iCrdRet = 0;
    repeat (2) @(posedge clk);
    model_reset();

    // Local-only drain until credits run out
    lq.push_back(64'hA1); lq.push_back(64'hA2); lq.push_back(64'hA3);
    repeat (3) step(1, 0, '0, 0);
    check("dir_dat_a2", oDat, 64'hA2);
    check("dir_crd0", oCrd, 4'd0);
    check("dir_tx2", oTxCnt, 16'd2);

    // One credit back releases exactly one flit
    step(1, 0, '0, 1);
    step(1, 0, '0, 0);
    step(1, 0, '0, 1);
    check("dir_a3", oDat, 64'hA3);
    step(1, 0, '0, 1);

    // Starvation bound with credits returned each cycle
    lq.push_back(64'hBB);
    for (int i = 0; i < 10; i++) step(1, 1, 64'hC0 + 64'(i), 1);

    // Spurious credit return while full
    step(1, 0, '0, 0);
    step(1, 0, '0, 1);
    step(1, 1, 64'h55, 0);
    check("dir_err_sticky", oCrdErr, 1'b1);
    step(1, 0, '0, 1);

    // Reset while stalled with a pending local flit
    lq.push_back(64'hD1); lq.push_back(64'hD2);
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    lq.push_back(64'hD3);
    step(0, 0, '0, 0);
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    check("dir_after_rst", oDat, 64'hD3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, pv, cr;
      if (lq.size() < 2 && $urandom_range(1, 0) == 1) lq.push_back({$urandom, $urandom});
      r  = ($urandom_range(59, 0) != 0);
      pv = ($urandom_range(2, 0) != 0);
      pd = {$urandom, $urandom};
      cr = ((CREDITS - m_crd) > 0 && $urandom_range(1, 0) == 1) || ($urandom_range(29, 0) == 0);
      step(r, pv, pd, cr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
